color_seq_gen: RTL

COLOR_SEQ_GEN -- requirements
Module: color_seq_gen

---
 rtl/color_seq_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/color_seq_gen.sv
// color_seq_gen: 4-entry command FIFO feeding an RGB line sequencer.
// Each entry drives one colour (or dark) for HoldIn+1 cycles. GAP_CYCLES
// dark cycles follow each entry. NewColor strobes on each new non-dark colour.
module color_seq_gen #(
  parameter int GAP_CYCLES = 1,
  parameter int DEPTH      = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Push,
  input  logic [1:0] ColorIn,
  input  logic [3:0] HoldIn,
  output logic       Full,
  output logic       Red,
  output logic       Green,
  output logic       Blue,
  output logic       NewColor,
  output logic       Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // The gap counter runs from GAP_CYCLES-1 down to 0. It is unused when GAP_CYCLES is 0.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [2:0] FULL_CNT = 3'(DEPTH);

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] gap_q, gap_d;
  logic [2:0] rgb_q, rgb_d;
  logic       newcolor_q, newcolor_d;
  logic [5:0] mem_q [4];

  logic       push_ok;
  logic       pop;
  logic       load;
  logic [5:0] head;

  // Map a colour code to {Red,Green,Blue}. Code 11 is dark.
  function automatic logic [2:0] decode_color(input logic [1:0] code);
    case (code)
      2'b00:   decode_color = 3'b100;
      2'b01:   decode_color = 3'b010;
      2'b10:   decode_color = 3'b001;
      default: decode_color = 3'b000;
    endcase
  endfunction

  // Queue payload storage. Stale slots are never read because count guards every pop.
  always_ff @(posedge Clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ColorIn, HoldIn};
  end

  // Sequencer next state, queue bookkeeping and line values.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    gap_d      = gap_q;
    rgb_d      = rgb_q;
    load       = 1'b0;
    head       = mem_q[rd_ptr_q];
    // Full comes from the registered count only, so a same-cycle pop cannot admit a push.
    push_ok    = Push && (count_q != FULL_CNT);

    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) load = 1'b1;
      end
      S_DRIVE: begin
        if (hold_q != 4'd0) begin
          hold_d = hold_q - 4'd1;
        end else if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
          rgb_d   = 3'b000;
        end else if (count_q != 3'd0) begin
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
          rgb_d   = 3'b000;
        end
      end
      S_GAP: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (count_q != 3'd0) begin
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        rgb_d   = 3'b000;
      end
    endcase

    if (load) begin
      state_d = S_DRIVE;
      rgb_d   = decode_color(head[5:4]);
      hold_d  = head[3:0];
    end
    pop = load;

    wr_ptr_d = push_ok ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // Strobe only on entry into a lit colour that differs from the current one.
    newcolor_d = (rgb_d != 3'b000) && (rgb_d != rgb_q);
  end

  // Control and output registers. Reset clears them asynchronously.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      count_q    <= 3'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      hold_q     <= 4'd0;
      gap_q      <= 4'd0;
      rgb_q      <= 3'b000;
      newcolor_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      rgb_q      <= rgb_d;
      newcolor_q <= newcolor_d;
    end
  end

  assign Red      = rgb_q[2];
  assign Green    = rgb_q[1];
  assign Blue     = rgb_q[0];
  assign NewColor = newcolor_q;
  assign Full     = (count_q == FULL_CNT);
  assign Busy     = (state_q != S_IDLE) || (count_q != 3'd0);

endmodule
